// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and default widths for pipeline stage registers
package pipe_pkg;
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;
   localparam int DEF_DATA_W = 64;
   localparam int DEF_CTRL_W = 4;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with optional two-entry skid buffer
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CTRL_W = DEF_CTRL_W,
   parameter bit SKID   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
);
   state_t            r_state;
   state_t            w_next;
   logic              r_in_ready;
   logic [DATA_W-1:0] r_head_data;
   logic [DATA_W-1:0] r_skid_data;
   logic [CTRL_W-1:0] r_head_ctrl;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic              w_in_xfer;
   logic              w_out_xfer;
   logic              w_head_from_in;
   logic              w_head_from_skid;
   logic              w_skid_from_in;

   assign out_valid  = rst_n && (r_state != EMPTY);
   assign in_ready   = rst_n && (SKID ? r_in_ready : (!out_valid || out_ready));
   assign out_data   = out_valid ? r_head_data : '0;
   assign out_ctrl   = out_valid ? r_head_ctrl : '0;
   assign occupancy  = rst_n ? r_state : 2'd0;
   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = out_valid && out_ready;

   // next state and register load selects; flush overrides everything
   always_comb begin
      w_next           = r_state;
      w_head_from_in   = 1'b0;
      w_head_from_skid = 1'b0;
      w_skid_from_in   = 1'b0;
      case (r_state)
         EMPTY: begin
            w_next         = w_in_xfer ? ONE : EMPTY;
            w_head_from_in = w_in_xfer;
         end
         ONE: begin
            w_head_from_in = w_in_xfer && w_out_xfer;
            w_skid_from_in = w_in_xfer && !w_out_xfer && SKID;
            w_next         = w_skid_from_in ? TWO : (w_out_xfer && !w_in_xfer) ? EMPTY : ONE;
         end
         TWO: begin
            w_head_from_skid = w_out_xfer;
            w_next           = w_out_xfer ? ONE : TWO;
         end
         default: w_next = EMPTY;
      endcase
      if (flush) begin
         w_next           = EMPTY;
         w_head_from_in   = 1'b0;
         w_head_from_skid = 1'b0;
         w_skid_from_in   = 1'b0;
      end
   end

   // state register; in_ready is registered so it never depends on out_ready when skidding
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_next;
         r_in_ready <= (w_next != TWO);
      end
   end

   // head and skid payload registers; the skid entry moves to the head as the head drains
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head_data <= '0;
         r_head_ctrl <= '0;
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
      end else begin
         if (w_head_from_in) begin
            r_head_data <= in_data;
            r_head_ctrl <= in_ctrl;
         end else if (w_head_from_skid) begin
            r_head_data <= r_skid_data;
            r_head_ctrl <= r_skid_ctrl;
         end
         if (w_skid_from_in) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
         end
      end
   end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: queue-model checking of skid and non-skid stage registers
module tb_pipe_stage_reg;
   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [63:0] in_data;
   logic [3:0]  in_ctrl;
   logic        out_ready;
   logic        ir1, ov1, ir0, ov0;
   logic [63:0] od1, od0;
   logic [3:0]  oc1, oc0;
   logic [1:0]  occ1, occ0;
   logic [67:0] q1[$];
   logic [67:0] q0[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          m_i1, m_o1, m_i0, m_o0;
   logic [71:0] e1, e0;

   pipe_stage_reg #(.DATA_W(64), .CTRL_W(4), .SKID(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov1), .out_ready(out_ready),
      .out_data(od1), .out_ctrl(oc1), .occupancy(occ1)
   );

   pipe_stage_reg #(.DATA_W(64), .CTRL_W(4), .SKID(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov0), .out_ready(out_ready),
      .out_data(od0), .out_ctrl(oc0), .occupancy(occ0)
   );

   always #5 clk = ~clk;

   // expected {in_ready, out_valid, occupancy, out_ctrl, out_data} from a FIFO of held entries
   function automatic logic [71:0] expv(int sz, logic [67:0] head, bit skid, bit rn, bit ordy);
      logic ov;
      ov = rn && (sz > 0);
      return {rn && (skid ? (sz < 2) : (sz == 0 || ordy)), ov, rn ? 2'(sz) : 2'd0, ov ? head : 68'd0};
   endfunction

   // reference model: held entries as queues, capacity 2 with skid, 1 without
   initial forever begin
      @(posedge clk);
      m_i1 = in_valid && rst_n && (q1.size() < 2);
      m_o1 = out_ready && (q1.size() > 0);
      m_i0 = in_valid && rst_n && (q0.size() == 0 || out_ready);
      m_o0 = out_ready && (q0.size() > 0);
      if (!rst_n || flush) begin
         q1.delete();
         q0.delete();
      end else begin
         if (m_o1) void'(q1.pop_front());
         if (m_i1) q1.push_back({in_ctrl, in_data});
         if (m_o0) void'(q0.pop_front());
         if (m_i0) q0.push_back({in_ctrl, in_data});
      end
   end

   // compare both DUTs against the model every cycle, away from the clock edge
   initial forever begin
      @(negedge clk);
      e1 = expv(q1.size(), (q1.size() > 0) ? q1[0] : 68'd0, 1'b1, rst_n, out_ready);
      e0 = expv(q0.size(), (q0.size() > 0) ? q0[0] : 68'd0, 1'b0, rst_n, out_ready);
      n_tests += 2;
      if ({ir1, ov1, occ1, oc1, od1} !== e1) begin
         n_fail++;
         $display("FAIL cyc_skid1 t=%0t got=%h expected=%h", $time, {ir1, ov1, occ1, oc1, od1}, e1);
      end
      if ({ir0, ov0, occ0, oc0, od0} !== e0) begin
         n_fail++;
         $display("FAIL cyc_skid0 t=%0t got=%h expected=%h", $time, {ir0, ov0, occ0, oc0, od0}, e0);
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic cyc(input bit v, input logic [63:0] d, input logic [3:0] c, input bit ordy,
                      input bit fl = 1'b0, input bit rn = 1'b1);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
      rst_n     = rn;
      #1;
   endtask

   initial begin
      clk = 1'b0; rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
      in_data = '0; in_ctrl = '0; out_ready = 1'b0;
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("rst_occ", 64'(occ1), 0);
      chk("rst_in_ready", 64'(ir1), 0);
      cyc(0, 0, 0, 1);
      chk("post_rst_in_ready", 64'(ir1), 1);
      chk("post_rst_valid", 64'(ov1), 0);
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 64'(i), 4'(i), 1);
         if (i > 1) begin
            chk("stream_data", od1, 64'(i - 1));
            chk("stream_occ", 64'(occ1), 1);
         end
      end
      cyc(0, 0, 0, 1);
      chk("stream_last", od1, 8);
      cyc(0, 0, 0, 1);
      chk("stream_drained", 64'(ov1), 0);
      cyc(1, 64'hA, 4'h1, 0);
      cyc(1, 64'hB, 4'h2, 0);
      chk("stall_head", od1, 64'hA);
      chk("skid0_stall_in_ready", 64'(ir0), 0);
      cyc(0, 0, 0, 0);
      chk("stall_occ", 64'(occ1), 2);
      chk("stall_in_ready", 64'(ir1), 0);
      chk("stall_hold", od1, 64'hA);
      chk("model_occ", 64'(q1.size()), 2);
      cyc(0, 0, 0, 0);
      chk("stall_occ_held", 64'(occ1), 2);
      cyc(0, 0, 0, 1);
      chk("stall_out_a", od1, 64'hA);
      cyc(0, 0, 0, 1);
      chk("stall_out_b", od1, 64'hB);
      chk("stall_occ_one", 64'(occ1), 1);
      cyc(0, 0, 0, 1);
      chk("stall_drained", 64'(ov1), 0);
      cyc(1, 64'hA, 4'h1, 0);
      cyc(1, 64'hB, 4'h2, 0);
      cyc(0, 0, 0, 0);
      chk("flush_pre_occ", 64'(occ1), 2);
      cyc(1, 64'hC, 4'h3, 1, 1);
      chk("flush_head", od1, 64'hA);
      cyc(0, 0, 0, 1);
      chk("flush_valid", 64'(ov1), 0);
      chk("flush_ctrl", 64'(oc1), 0);
      chk("model_flush", 64'(q1.size()), 0);
      cyc(0, 0, 0, 1);
      chk("flush_no_c", 64'(ov1), 0);
      cyc(1, 64'hA, 4'h1, 0);
      cyc(1, 64'hB, 4'h2, 0);
      cyc(0, 0, 0, 0);
      chk("rst_pre_occ", 64'(occ1), 2);
      cyc(0, 0, 0, 0, 0, 0);
      chk("rst_mid_in_ready", 64'(ir1), 0);
      chk("rst_mid_occ", 64'(occ1), 0);
      cyc(0, 0, 0, 0);
      chk("rst_after_occ", 64'(occ1), 0);
      chk("rst_after_data", od1, 0);
      chk("rst_after_ctrl", 64'(oc1), 0);
      chk("rst_after_in_ready", 64'(ir1), 1);
      cyc(1, 64'h11, 4'h1, 1);
      cyc(1, 64'h22, 4'h2, 1);
      chk("skid0_head", od0, 64'h11);
      cyc(0, 0, 0, 1);
      chk("skid0_replace", od0, 64'h22);
      chk("skid0_occ", 64'(occ0), 1);
      cyc(0, 64'hDEAD, 4'hF, 1);
      cyc(0, 64'hDEAD, 4'hF, 1);
      chk("bubble_valid", 64'(ov1), 0);
      chk("bubble_ctrl", 64'(oc1), 0);
      chk("bubble_data", od1, 0);
      chk("bubble_ctrl0", 64'(oc0), 0);
      repeat (3000) begin
         cyc(1'($urandom_range(0, 1)), {$urandom, $urandom}, 4'($urandom),
             $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 63) != 0);
      end
      cyc(0, 0, 0, 1);
      @(negedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The module SHALL have parameter DATA_W, default 64: payload width (ALU result, store data, PC+4, immediate, rd packed by caller).
REQ-002 The module SHALL have parameter CTRL_W, default 4: control bits (RegWrite, MemWrite, ResultSrc) forced to zero on bubble/flush.
REQ-003 The module SHALL have parameter SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
REQ-004 The module SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 flush  input  1  kill all held entries and any input offered this cycle.
REQ-008 in_valid  input  1  upstream holds a valid instruction.
REQ-009 in_ready  output  1  stage accepts the input this cycle.
REQ-010 in_data  input  DATA_W  upstream payload.
REQ-011 in_ctrl  input  CTRL_W  upstream control bits.
REQ-012 out_valid  output  1  stage presents a valid instruction.
REQ-013 out_ready  input  1  downstream accepts (0 = stall).
REQ-014 out_data  output  DATA_W  head payload.
REQ-015 out_ctrl  output  CTRL_W  head control bits.
REQ-016 occupancy  output  2  number of held entries (0..2).

Function
REQ-017 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-018 The state machine SHALL have states EMPTY, ONE and TWO; TWO SHALL be reachable only when SKID=1.
REQ-019 EMPTY SHALL go to ONE on an input transfer, otherwise stay EMPTY.
REQ-020 ONE SHALL go to EMPTY on an output transfer without an input transfer.
REQ-021 ONE SHALL stay ONE, with the head reloaded from the input, when input and output transfers occur together.
REQ-022 ONE with an input transfer and no output transfer SHALL go to TWO, with the new entry in the skid register; this case SHALL be impossible when SKID=0.
REQ-023 TWO SHALL go to ONE on an output transfer, with the skid entry moving to the head the same edge.
REQ-024 When SKID=1, in_ready SHALL be registered: 1 in EMPTY and ONE, 0 in TWO.
REQ-025 When SKID=0, in_ready SHALL equal !out_valid || out_ready.
REQ-026 Latency from input transfer to out_valid SHALL be exactly 1 cycle; throughput SHALL be 1 per cycle when out_ready=1.
REQ-027 Order SHALL be strictly FIFO; no entry SHALL be dropped or duplicated except by flush or reset.
REQ-028 When out_valid=0, out_ctrl and out_data SHALL be 0 (bubble).
REQ-029 Flush SHALL have highest priority: the next state SHALL be EMPTY and any input offered that cycle SHALL be discarded.
REQ-030 An output transfer in the flush cycle SHALL still count as consumed.
REQ-031 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE or TWO respectively.
REQ-032 Payload bits SHALL pass unmodified; there SHALL be no width change.

Reset
REQ-033 While rst_n=0 at a clock edge, the state SHALL become EMPTY and all data/ctrl registers SHALL become 0.
REQ-034 While rst_n=0, out_valid, in_ready and occupancy SHALL be 0 and out_ctrl/out_data SHALL be 0.
REQ-035 A reset asserted mid-operation SHALL discard all entries with no partial output; in_ready SHALL be 1 on the first cycle after rst_n rises.

Structure
REQ-036 A shared package pipe_pkg SHALL hold the state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the default DATA_W/CTRL_W constants.
REQ-037 The block SHALL be a single module with no sub-module; head and skid registers SHALL be inline.

Verification
REQ-038 Stream: in_data 1..8 offered back-to-back, out_ready=1 -> out_data 1..8 on consecutive cycles starting 1 cycle after the first transfer, occupancy=1 throughout.
REQ-039 Stall: A accepted, then B offered with out_ready=0 for 3 cycles -> (SKID=1) occupancy=2, in_ready=0, out_data=A held; out_ready=1 -> A then B.
REQ-040 Flush: state TWO holding A,B, flush=1 with C offered and out_ready=1 -> A consumed that cycle; next cycle out_valid=0, out_ctrl=0, C never appears.
REQ-041 Reset: rst_n=0 for 1 cycle while in TWO -> next cycle occupancy=0, out_data=0, out_ctrl=0; in_ready=1 after rst_n rises.
REQ-042 SKID=0: out_ready=0 with head valid -> in_ready=0 the same cycle; out_ready=1 with in_valid=1 -> head replaced, occupancy stays 1.
REQ-043 Bubble: in_valid=0 with in_ctrl=4'hF, in_data=64'hDEAD -> out_valid=0 and out_ctrl=0 the next cycle.
